// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory load/store with wait states,
// one-entry skid buffer, bus timeout and load formatting.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        EX_MEM_enable_out,
  input  logic [31:0] EX_MEM_PC,
  input  logic [31:0] EX_MEM_ALUResult,
  input  logic [31:0] EX_MEM_WriteData,
  input  logic [4:0]  EX_MEM_Rd,
  input  logic [2:0]  EX_MEM_Funct3,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic        EX_MEM_MemToReg,
  input  logic        EX_MEM_RegWrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] MEM_WB_PC,
  output logic [31:0] MEM_WB_ALUResult,
  output logic [31:0] MEM_WB_ReadData,
  output logic [4:0]  MEM_WB_Rd,
  output logic        MEM_WB_MemToReg,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_enable_out,
  output logic        MEM_stall,
  output logic        MEM_misaligned,
  output logic        MEM_bus_error,
  output logic [31:0] MEM_fault_addr
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [31:0] TMO_LAST = TIMEOUT_CYCLES - 1;

  state_t      state_q, state_d;
  logic [31:0] tmo_q, tmo_d;

  logic        sk_full_q, sk_full_d;
  logic [31:0] sk_pc_q, sk_pc_d;
  logic [31:0] sk_alu_q, sk_alu_d;
  logic [31:0] sk_wd_q, sk_wd_d;
  logic [4:0]  sk_rd_q, sk_rd_d;
  logic [2:0]  sk_f3_q, sk_f3_d;
  logic        sk_mr_q, sk_mr_d;
  logic        sk_mw_q, sk_mw_d;
  logic        sk_m2r_q, sk_m2r_d;
  logic        sk_rw_q, sk_rw_d;

  logic [31:0] op_pc_q, op_pc_d;
  logic [31:0] op_addr_q, op_addr_d;
  logic [31:0] op_wdata_q, op_wdata_d;
  logic [3:0]  op_be_q, op_be_d;
  logic        op_we_q, op_we_d;
  logic [4:0]  op_rd_q, op_rd_d;
  logic [2:0]  op_f3_q, op_f3_d;
  logic        op_m2r_q, op_m2r_d;
  logic        op_rw_q, op_rw_d;

  logic [31:0] wb_pc_q, wb_pc_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_m2r_q, wb_m2r_d;
  logic        wb_rw_q, wb_rw_d;
  logic        wb_en_q, wb_en_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;
  logic [31:0] faddr_q, faddr_d;

  // Selected source op: skid has priority to keep program order
  logic        src_valid;
  logic [31:0] src_pc, src_alu, src_wd;
  logic [4:0]  src_rd;
  logic [2:0]  src_f3;
  logic        src_mr, src_mw, src_m2r, src_rw;
  logic        src_mem, src_mis;
  logic [1:0]  src_lane;
  logic [3:0]  src_be;
  logic [31:0] src_wdata;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    src_valid = sk_full_q | EX_MEM_enable_out;
    src_pc    = sk_full_q ? sk_pc_q  : EX_MEM_PC;
    src_alu   = sk_full_q ? sk_alu_q : EX_MEM_ALUResult;
    src_wd    = sk_full_q ? sk_wd_q  : EX_MEM_WriteData;
    src_rd    = sk_full_q ? sk_rd_q  : EX_MEM_Rd;
    src_f3    = sk_full_q ? sk_f3_q  : EX_MEM_Funct3;
    src_mr    = sk_full_q ? sk_mr_q  : EX_MEM_MemRead;
    src_mw    = sk_full_q ? sk_mw_q  : EX_MEM_MemWrite;
    src_m2r   = sk_full_q ? sk_m2r_q : EX_MEM_MemToReg;
    src_rw    = sk_full_q ? sk_rw_q  : EX_MEM_RegWrite;
    src_mem   = src_mr | src_mw;
    src_lane  = src_alu[1:0];
    src_mis   = 1'b0;
    src_be    = 4'b1111;
    src_wdata = src_wd;
    unique case (src_f3[1:0])
      2'b00: begin
        src_be    = 4'b0001 << src_lane;
        src_wdata = {4{src_wd[7:0]}};
      end
      2'b01: begin
        src_mis   = src_lane[0];
        src_be    = 4'b0011 << src_lane;
        src_wdata = {2{src_wd[15:0]}};
      end
      default: src_mis = |src_lane;
    endcase
  end

  always_comb begin
    ld_byte = 8'(dmem_rdata >> {op_addr_q[1:0], 3'b000});
    ld_half = op_addr_q[1] ? dmem_rdata[31:16]
                           : dmem_rdata[15:0];
    unique case (op_f3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    sk_full_d  = sk_full_q;
    sk_pc_d    = sk_pc_q;
    sk_alu_d   = sk_alu_q;
    sk_wd_d    = sk_wd_q;
    sk_rd_d    = sk_rd_q;
    sk_f3_d    = sk_f3_q;
    sk_mr_d    = sk_mr_q;
    sk_mw_d    = sk_mw_q;
    sk_m2r_d   = sk_m2r_q;
    sk_rw_d    = sk_rw_q;
    op_pc_d    = op_pc_q;
    op_addr_d  = op_addr_q;
    op_wdata_d = op_wdata_q;
    op_be_d    = op_be_q;
    op_we_d    = op_we_q;
    op_rd_d    = op_rd_q;
    op_f3_d    = op_f3_q;
    op_m2r_d   = op_m2r_q;
    op_rw_d    = op_rw_q;
    wb_pc_d    = wb_pc_q;
    wb_alu_d   = wb_alu_q;
    wb_rdata_d = wb_rdata_q;
    wb_rd_d    = wb_rd_q;
    wb_m2r_d   = wb_m2r_q;
    wb_rw_d    = wb_rw_q;
    wb_en_d    = 1'b0;
    mis_d      = 1'b0;
    berr_d     = 1'b0;
    faddr_d    = faddr_q;

    // New arrival goes to the skid whenever it cannot be the source
    if (EX_MEM_enable_out &&
        (state_q == S_WAIT || sk_full_q)) begin
      sk_full_d = 1'b1;
      sk_pc_d   = EX_MEM_PC;
      sk_alu_d  = EX_MEM_ALUResult;
      sk_wd_d   = EX_MEM_WriteData;
      sk_rd_d   = EX_MEM_Rd;
      sk_f3_d   = EX_MEM_Funct3;
      sk_mr_d   = EX_MEM_MemRead;
      sk_mw_d   = EX_MEM_MemWrite;
      sk_m2r_d  = EX_MEM_MemToReg;
      sk_rw_d   = EX_MEM_RegWrite;
    end

    unique case (state_q)
      S_IDLE: begin
        if (src_valid) begin
          if (sk_full_q && !EX_MEM_enable_out)
            sk_full_d = 1'b0;
          if (src_mem && !src_mis) begin
            state_d    = S_WAIT;
            tmo_d      = 32'd0;
            op_pc_d    = src_pc;
            op_addr_d  = src_alu;
            op_wdata_d = src_wdata;
            op_be_d    = src_be;
            op_we_d    = src_mw;
            op_rd_d    = src_rd;
            op_f3_d    = src_f3;
            op_m2r_d   = src_m2r;
            op_rw_d    = src_rw;
          end else begin
            wb_en_d    = 1'b1;
            wb_pc_d    = src_pc;
            wb_alu_d   = src_alu;
            wb_rdata_d = 32'd0;
            wb_rd_d    = src_rd;
            wb_m2r_d   = src_m2r;
            wb_rw_d    = src_rw & ~src_mem;
            if (src_mem) begin
              mis_d   = 1'b1;
              faddr_d = src_alu;
            end
          end
        end
      end
      S_WAIT: begin
        if (dmem_ready) begin
          state_d    = S_IDLE;
          wb_en_d    = 1'b1;
          wb_pc_d    = op_pc_q;
          wb_alu_d   = op_addr_q;
          wb_rdata_d = op_we_q ? 32'd0 : ld_data;
          wb_rd_d    = op_rd_q;
          wb_m2r_d   = op_m2r_q;
          wb_rw_d    = op_rw_q;
        end else if (TIMEOUT_CYCLES != 0 &&
                     tmo_q == TMO_LAST) begin
          state_d    = S_IDLE;
          wb_en_d    = 1'b1;
          wb_pc_d    = op_pc_q;
          wb_alu_d   = op_addr_q;
          wb_rdata_d = 32'd0;
          wb_rd_d    = op_rd_q;
          wb_m2r_d   = op_m2r_q;
          wb_rw_d    = 1'b0;
          berr_d     = 1'b1;
          faddr_d    = op_addr_q;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tmo_q      <= '0;
      sk_full_q  <= 1'b0;
      sk_pc_q    <= '0;
      sk_alu_q   <= '0;
      sk_wd_q    <= '0;
      sk_rd_q    <= '0;
      sk_f3_q    <= '0;
      sk_mr_q    <= 1'b0;
      sk_mw_q    <= 1'b0;
      sk_m2r_q   <= 1'b0;
      sk_rw_q    <= 1'b0;
      op_pc_q    <= '0;
      op_addr_q  <= '0;
      op_wdata_q <= '0;
      op_be_q    <= '0;
      op_we_q    <= 1'b0;
      op_rd_q    <= '0;
      op_f3_q    <= '0;
      op_m2r_q   <= 1'b0;
      op_rw_q    <= 1'b0;
      wb_pc_q    <= '0;
      wb_alu_q   <= '0;
      wb_rdata_q <= '0;
      wb_rd_q    <= '0;
      wb_m2r_q   <= 1'b0;
      wb_rw_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
      faddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      sk_full_q  <= sk_full_d;
      sk_pc_q    <= sk_pc_d;
      sk_alu_q   <= sk_alu_d;
      sk_wd_q    <= sk_wd_d;
      sk_rd_q    <= sk_rd_d;
      sk_f3_q    <= sk_f3_d;
      sk_mr_q    <= sk_mr_d;
      sk_mw_q    <= sk_mw_d;
      sk_m2r_q   <= sk_m2r_d;
      sk_rw_q    <= sk_rw_d;
      op_pc_q    <= op_pc_d;
      op_addr_q  <= op_addr_d;
      op_wdata_q <= op_wdata_d;
      op_be_q    <= op_be_d;
      op_we_q    <= op_we_d;
      op_rd_q    <= op_rd_d;
      op_f3_q    <= op_f3_d;
      op_m2r_q   <= op_m2r_d;
      op_rw_q    <= op_rw_d;
      wb_pc_q    <= wb_pc_d;
      wb_alu_q   <= wb_alu_d;
      wb_rdata_q <= wb_rdata_d;
      wb_rd_q    <= wb_rd_d;
      wb_m2r_q   <= wb_m2r_d;
      wb_rw_q    <= wb_rw_d;
      wb_en_q    <= wb_en_d;
      mis_q      <= mis_d;
      berr_q     <= berr_d;
      faddr_q    <= faddr_d;
    end
  end

  assign dmem_req   = (state_q == S_WAIT);
  assign dmem_we    = (state_q == S_WAIT) & op_we_q;
  assign dmem_addr  = op_addr_q;
  assign dmem_wdata = op_wdata_q;
  assign dmem_be    = op_be_q;
  assign MEM_stall  = (state_q == S_WAIT) | sk_full_q;

  assign MEM_WB_PC         = wb_pc_q;
  assign MEM_WB_ALUResult  = wb_alu_q;
  assign MEM_WB_ReadData   = wb_rdata_q;
  assign MEM_WB_Rd         = wb_rd_q;
  assign MEM_WB_MemToReg   = wb_m2r_q;
  assign MEM_WB_RegWrite   = wb_rw_q;
  assign MEM_WB_enable_out = wb_en_q;
  assign MEM_misaligned    = mis_q;
  assign MEM_bus_error     = berr_q;
  assign MEM_fault_addr    = faddr_q;

  skid_ovf_a: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(EX_MEM_enable_out && sk_full_q && state_q == S_WAIT));

endmodule
